mem_port_arbiter: RTL and testbench

Shares the single translated memory bus between the instruction-fetch port and the data port. It arbitrates round-robin between the two, translates the winner's virtual address through the codebase's memory_map (ENABLE_TLB=0), and raises a user-mode address exception without touching the bus. Otherwise it runs one outstanding bus transaction to completion and returns the result to the granted requester. It sits between the pipeline's IF/MEM stages and the cache/uncached bus bridge.

---
 rtl/mem_arb_pkg.sv | 40 ++++
 rtl/memory_map.sv | 49 ++++
 rtl/rr_arb2.sv | 29 ++
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory port arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which requester owns the current transaction
//   arb_req_t   : latched bus request (we, be, addr, wdata)
//   fetch_req() : builds the request a fetch implies (read, all bytes)
package mem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      RESP  = 3'd3,
      ERR   = 3'd4
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_t;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } arb_req_t;

   localparam logic [3:0] FETCH_BE = 4'hF;

   // Fetches are always full-word reads; wdata is parked at zero.
   function automatic arb_req_t fetch_req(input logic [31:0] paddr);
      arb_req_t r;
      r.we    = 1'b0;
      r.be    = FETCH_BE;
      r.addr  = paddr;
      r.wdata = 32'h0000_0000;
      return r;
   endfunction

endpackage

// File: rtl/memory_map.sv
// memory_map: fixed (TLB-less) virtual-to-physical segment mapping.
// Ports:
//   en             in  1   translation enable; when 0 the address passes through
//   user_mode      in  1   CPU is in user mode
//   kseg0_uncached in  1   kseg0 accesses are uncached
//   vaddr          in  32  virtual address
//   paddr          out 32  physical address
//   uncached       out 1   access must bypass the cache
//   except_user    out 1   user-mode access to a kernel segment
module memory_map (
   input  logic        en,
   input  logic        user_mode,
   input  logic        kseg0_uncached,
   input  logic [31:0] vaddr,
   output logic [31:0] paddr,
   output logic        uncached,
   output logic        except_user
);

   // Segment decode: kseg0/kseg1 fold onto the low 512 MB, everything else maps 1:1.
   always_comb begin
      paddr       = vaddr;
      uncached    = 1'b0;
      except_user = 1'b0;
      if (en) begin
         // Any address with bit 31 set is kernel-only.
         except_user = user_mode & vaddr[31];
         case (vaddr[31:29])
            3'b100: begin
               paddr    = {3'b000, vaddr[28:0]};
               uncached = kseg0_uncached;
            end
            3'b101: begin
               paddr    = {3'b000, vaddr[28:0]};
               uncached = 1'b1;
            end
            default: begin
               paddr    = vaddr;
               uncached = 1'b0;
            end
         endcase
      end else begin
         paddr       = vaddr;
         uncached    = 1'b0;
         except_user = 1'b0;
      end
   end

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant.
// Ports:
//   req  in  2  request vector (bit 0 = port 0, bit 1 = port 1)
//   en   in  1  grants allowed this cycle
//   last in  1  index of the port granted most recently
//   gnt  out 2  one-hot grant (zero when disabled or no request)
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       en,
   input  logic       last,
   output logic [1:0] gnt
);

   // Single requester wins outright; on contention the port not served last wins.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
         endcase
      end else begin
         gnt = 2'b00;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one translated memory bus between the fetch port
// (i_*) and the data port (d_*). Round-robin grant, address translation at
// grant time, one outstanding bus transaction, response routed to the owner.
// Kernel-segment accesses from user mode complete with an exception and
// never reach the bus.
// Ports:
//   clk, rst                       clock, async active-high reset
//   user_mode, kseg0_uncached      CP0 state sampled at grant
//   i_req/i_addr -> i_ack          fetch request / accept pulse
//   i_rvalid/i_rdata/i_except      fetch response
//   d_req/d_we/d_be/d_addr/d_wdata -> d_ack   data request / accept pulse
//   d_rvalid/d_rdata/d_except      data response
//   bus_req/we/be/addr/wdata/uncached, bus_ready   downstream request
//   bus_rvalid/bus_rdata           downstream completion
module mem_port_arbiter
   import mem_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        user_mode,
   input  logic        kseg0_uncached,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_except,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_except,
   output logic        bus_req,
   output logic        bus_we,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        bus_uncached,
   input  logic        bus_ready,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   arb_state_t  state_r, state_nxt_s;
   arb_owner_t  owner_r;
   arb_owner_t  last_r;
   arb_req_t    req_r, req_nxt_s;
   logic        unc_r;
   logic [31:0] rdata_r;

   logic [1:0]  gnt_s;
   logic        grant_s;
   logic [31:0] win_addr_s;
   logic [31:0] map_paddr_s;
   logic        map_unc_s;
   logic        map_exc_s;
   logic        resp_s;
   logic        err_s;

   rr_arb2 u_arb (
      .req  ({d_req, i_req}),
      .en   (state_r == IDLE),
      .last (last_r == OWN_D),
      .gnt  (gnt_s)
   );

   assign grant_s    = gnt_s[0] | gnt_s[1];
   assign win_addr_s = gnt_s[1] ? d_addr : i_addr;

   // One translator shared by both ports, fed with the winner's address.
   memory_map u_map (
      .en             (1'b1),
      .user_mode      (user_mode),
      .kseg0_uncached (kseg0_uncached),
      .vaddr          (win_addr_s),
      .paddr          (map_paddr_s),
      .uncached       (map_unc_s),
      .except_user    (map_exc_s)
   );

   // Accept is combinational so the requester sees it in the grant cycle.
   assign i_ack = gnt_s[0];
   assign d_ack = gnt_s[1];

   // Build the request to latch for the winning port.
   always_comb begin
      req_nxt_s = fetch_req(map_paddr_s);
      if (gnt_s[1]) begin
         req_nxt_s.we    = d_we;
         req_nxt_s.be    = d_be;
         req_nxt_s.wdata = d_wdata;
      end else begin
         req_nxt_s = fetch_req(map_paddr_s);
      end
   end

   // Next-state logic for the transaction FSM.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_s) begin
               state_nxt_s = map_exc_s ? ERR : ISSUE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            if (bus_ready) begin
               state_nxt_s = WAIT;
            end else begin
               state_nxt_s = ISSUE;
            end
         end
         WAIT: begin
            // Only a completion seen here counts; stray rvalid elsewhere is dropped.
            if (bus_rvalid) begin
               state_nxt_s = RESP;
            end else begin
               state_nxt_s = WAIT;
            end
         end
         RESP:    state_nxt_s = IDLE;
         ERR:     state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Capture the winner's translated request, owner and round-robin history at grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_r   <= '0;
         unc_r   <= 1'b0;
         owner_r <= OWN_I;
         last_r  <= OWN_I;
      end else if (grant_s) begin
         req_r   <= req_nxt_s;
         unc_r   <= map_unc_s;
         owner_r <= gnt_s[1] ? OWN_D : OWN_I;
         last_r  <= gnt_s[1] ? OWN_D : OWN_I;
      end
   end

   // Capture the completion data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_r <= 32'h0000_0000;
      end else if ((state_r == WAIT) && bus_rvalid) begin
         rdata_r <= bus_rdata;
      end
   end

   // Bus fields come straight from the latch so they stay stable under backpressure.
   assign bus_req      = (state_r == ISSUE);
   assign bus_we       = req_r.we;
   assign bus_be       = req_r.be;
   assign bus_addr     = req_r.addr;
   assign bus_wdata    = req_r.wdata;
   assign bus_uncached = unc_r;

   assign resp_s = (state_r == RESP);
   assign err_s  = (state_r == ERR);

   // Responses go only to the owner; the other port's outputs stay at zero.
   assign i_rvalid = (resp_s | err_s) & (owner_r == OWN_I);
   assign i_except = err_s & (owner_r == OWN_I);
   assign i_rdata  = (resp_s && (owner_r == OWN_I)) ? rdata_r : 32'h0000_0000;
   assign d_rvalid = (resp_s | err_s) & (owner_r == OWN_D);
   assign d_except = err_s & (owner_r == OWN_D);
   assign d_rdata  = (resp_s && (owner_r == OWN_D)) ? rdata_r : 32'h0000_0000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        user_mode;
   logic        kseg0_uncached;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        i_except;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_except;
   logic        bus_req;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_uncached;
   logic        bus_ready;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   int total = 0;
   int bad   = 0;
   logic exp_d;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .user_mode      (user_mode),
      .kseg0_uncached (kseg0_uncached),
      .i_req          (i_req),
      .i_addr         (i_addr),
      .i_ack          (i_ack),
      .i_rvalid       (i_rvalid),
      .i_rdata        (i_rdata),
      .i_except       (i_except),
      .d_req          (d_req),
      .d_we           (d_we),
      .d_be           (d_be),
      .d_addr         (d_addr),
      .d_wdata        (d_wdata),
      .d_ack          (d_ack),
      .d_rvalid       (d_rvalid),
      .d_rdata        (d_rdata),
      .d_except       (d_except),
      .bus_req        (bus_req),
      .bus_we         (bus_we),
      .bus_be         (bus_be),
      .bus_addr       (bus_addr),
      .bus_wdata      (bus_wdata),
      .bus_uncached   (bus_uncached),
      .bus_ready      (bus_ready),
      .bus_rvalid     (bus_rvalid),
      .bus_rdata      (bus_rdata)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk_eq({tag, "_i_ack"},    i_ack,        32'h0);
      chk_eq({tag, "_d_ack"},    d_ack,        32'h0);
      chk_eq({tag, "_i_rvalid"}, i_rvalid,     32'h0);
      chk_eq({tag, "_d_rvalid"}, d_rvalid,     32'h0);
      chk_eq({tag, "_i_rdata"},  i_rdata,      32'h0);
      chk_eq({tag, "_d_rdata"},  d_rdata,      32'h0);
      chk_eq({tag, "_i_except"}, i_except,     32'h0);
      chk_eq({tag, "_d_except"}, d_except,     32'h0);
      chk_eq({tag, "_bus_req"},  bus_req,      32'h0);
      chk_eq({tag, "_bus_we"},   bus_we,       32'h0);
      chk_eq({tag, "_bus_be"},   bus_be,       32'h0);
      chk_eq({tag, "_bus_addr"}, bus_addr,     32'h0);
      chk_eq({tag, "_bus_wd"},   bus_wdata,    32'h0);
      chk_eq({tag, "_bus_unc"},  bus_uncached, 32'h0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete bus transaction with bus_ready high and completion one cycle after accept.
   task automatic txn(input string tag, input logic port_d, input logic we,
                      input logic [3:0] be, input logic [31:0] va, input logic [31:0] wd,
                      input logic [31:0] rd, input logic [31:0] exp_pa, input logic exp_unc);
      if (port_d) begin
         d_req = 1'b1; d_we = we; d_be = be; d_addr = va; d_wdata = wd;
      end else begin
         i_req = 1'b1; i_addr = va;
      end
      @(negedge clk);
      chk_eq({tag, "_i_ack"}, i_ack, {31'h0, ~port_d});
      chk_eq({tag, "_d_ack"}, d_ack, {31'h0, port_d});
      step();
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      chk_eq({tag, "_bus_req"},  bus_req,      32'h1);
      chk_eq({tag, "_bus_addr"}, bus_addr,     exp_pa);
      chk_eq({tag, "_bus_unc"},  bus_uncached, {31'h0, exp_unc});
      chk_eq({tag, "_bus_we"},   bus_we,       {31'h0, port_d ? we : 1'b0});
      chk_eq({tag, "_bus_be"},   bus_be,       {28'h0, port_d ? be : 4'hF});
      chk_eq({tag, "_bus_wd"},   bus_wdata,    port_d ? wd : 32'h0);
      step();
      bus_rvalid = 1'b1; bus_rdata = rd;
      @(negedge clk);
      chk_eq({tag, "_wait_req"}, bus_req, 32'h0);
      chk_eq({tag, "_wait_rv"},  {31'h0, i_rvalid | d_rvalid}, 32'h0);
      step();
      bus_rvalid = 1'b0;
      @(negedge clk);
      chk_eq({tag, "_i_rvalid"}, i_rvalid, {31'h0, ~port_d});
      chk_eq({tag, "_d_rvalid"}, d_rvalid, {31'h0, port_d});
      chk_eq({tag, "_i_rdata"},  i_rdata,  port_d ? 32'h0 : rd);
      chk_eq({tag, "_d_rdata"},  d_rdata,  port_d ? rd : 32'h0);
      chk_eq({tag, "_except"},   {31'h0, i_except | d_except}, 32'h0);
      step();
   endtask

   initial begin
      rst = 1'b1; user_mode = 1'b0; kseg0_uncached = 1'b0;
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
      bus_ready = 1'b1; bus_rvalid = 1'b0; bus_rdata = 32'h0;

      @(negedge clk);
      chk_reset_outputs("rst");
      step();
      rst = 1'b0;

      // Both ports held: strict alternation D, I, D, I starting with data after reset.
      i_req = 1'b1; i_addr = 32'h8000_0200;
      d_req = 1'b1; d_addr = 32'h8000_0300; d_we = 1'b0; d_be = 4'hF;
      for (int k = 0; k < 4; k++) begin
         exp_d = ((k % 2) == 0);
         @(negedge clk);
         chk_eq("rr_d_ack", d_ack, {31'h0, exp_d});
         chk_eq("rr_i_ack", i_ack, {31'h0, ~exp_d});
         step();
         @(negedge clk);
         chk_eq("rr_bus_req",  bus_req,  32'h1);
         chk_eq("rr_bus_addr", bus_addr, exp_d ? 32'h0000_0300 : 32'h0000_0200);
         chk_eq("rr_issue_ack", {31'h0, i_ack | d_ack}, 32'h0);
         step();
         bus_rvalid = 1'b1; bus_rdata = 32'hC0DE_0000 + k;
         @(negedge clk);
         chk_eq("rr_wait_req", bus_req, 32'h0);
         chk_eq("rr_wait_ack", {31'h0, i_ack | d_ack}, 32'h0);
         step();
         bus_rvalid = 1'b0;
         @(negedge clk);
         chk_eq("rr_d_rvalid", d_rvalid, {31'h0, exp_d});
         chk_eq("rr_i_rvalid", i_rvalid, {31'h0, ~exp_d});
         chk_eq("rr_rdata", exp_d ? d_rdata : i_rdata, 32'hC0DE_0000 + k);
         chk_eq("rr_resp_ack", {31'h0, i_ack | d_ack}, 32'h0);
         step();
         if (k == 3) begin
            i_req = 1'b0; d_req = 1'b0;
         end
      end

      // Single fetch from kseg0 (cached) and a data write to kseg1 (uncached).
      txn("fetch", 1'b0, 1'b0, 4'h0, 32'h8000_0100, 32'h0, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0);
      txn("dwrite", 1'b1, 1'b1, 4'b0011, 32'hA000_0010, 32'h1234_5678, 32'h0BAD_F00D,
          32'h0000_0010, 1'b1);

      // User-mode access to kseg0: exception next cycle, bus untouched.
      user_mode = 1'b1;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h8000_0000;
      @(negedge clk);
      chk_eq("err_d_ack",   d_ack,   32'h1);
      chk_eq("err_req_ack", bus_req, 32'h0);
      step();
      d_req = 1'b0; user_mode = 1'b0;
      @(negedge clk);
      chk_eq("err_d_rvalid", d_rvalid, 32'h1);
      chk_eq("err_d_except", d_except, 32'h1);
      chk_eq("err_d_rdata",  d_rdata,  32'h0);
      chk_eq("err_bus_req",  bus_req,  32'h0);
      chk_eq("err_i_rvalid", i_rvalid, 32'h0);
      step();
      @(negedge clk);
      chk_eq("err_after_rv", d_rvalid, 32'h0);
      chk_eq("err_after_ex", d_except, 32'h0);
      step();

      // Backpressure: bus_ready low for 3 cycles, stray rvalid in ISSUE ignored.
      bus_ready = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'b1100; d_addr = 32'h0000_4000;
      @(negedge clk);
      chk_eq("stall_d_ack", d_ack, 32'h1);
      step();
      d_req = 1'b0; d_addr = 32'hFFFF_FFF0; d_be = 4'h0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk_eq("stall_bus_req",  bus_req,      32'h1);
         chk_eq("stall_bus_addr", bus_addr,     32'h0000_4000);
         chk_eq("stall_bus_be",   bus_be,       32'h0000_000C);
         chk_eq("stall_bus_unc",  bus_uncached, 32'h0);
         chk_eq("stall_d_rvalid", d_rvalid,     32'h0);
         step();
         bus_rvalid = (c == 0);
         bus_rdata  = 32'hBAD0_0001;
         if (c == 2) begin
            bus_ready = 1'b1;
         end
      end
      @(negedge clk);
      chk_eq("stall_acc_req",  bus_req,  32'h1);
      chk_eq("stall_acc_addr", bus_addr, 32'h0000_4000);
      step();
      @(negedge clk);
      chk_eq("stall_wait_req", bus_req,  32'h0);
      chk_eq("stall_wait_rv",  d_rvalid, 32'h0);
      step();
      bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
      @(negedge clk);
      chk_eq("stall_pre_rv", d_rvalid, 32'h0);
      step();
      bus_rvalid = 1'b0;
      @(negedge clk);
      chk_eq("stall_d_rv",    d_rvalid, 32'h1);
      chk_eq("stall_d_rdata", d_rdata,  32'h5555_AAAA);
      step();

      // Reset pulsed while waiting for completion.
      i_req = 1'b1; i_addr = 32'h8000_0400;
      @(negedge clk);
      chk_eq("mrst_i_ack", i_ack, 32'h1);
      step();
      i_req = 1'b0;
      @(negedge clk);
      chk_eq("mrst_bus_req", bus_req, 32'h1);
      step();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk_reset_outputs("mrst");
      step();
      rst = 1'b0;
      bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      chk_eq("mrst_late_irv", i_rvalid, 32'h0);
      step();
      bus_rvalid = 1'b0;
      @(negedge clk);
      chk_eq("mrst_late_irv2", i_rvalid, 32'h0);
      chk_eq("mrst_late_drv2", d_rvalid, 32'h0);
      step();

      // Normal grant afterwards; kseg0 with Config.K0 uncached.
      kseg0_uncached = 1'b1;
      txn("post", 1'b1, 1'b0, 4'hF, 32'h9000_0000, 32'h0, 32'h7777_0001, 32'h1000_0000, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
